// File: rtl/rca_add_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// add_seq_pkg
//
// Purpose : shared constants, FSM state encoding and helper functions for
//           the multi-cycle ripple-carry add sequencer.
// Contents: DEFAULT_WIDTH / DEFAULT_SLICE  default operand and slice widths
//           ST_IDLE / ST_RUN / ST_DONE      sequencer state encoding
//           idx_width()                     width of the slice index counter
// Optional: ADD_SEQ_SUBTRACT_EN (used by the interface and top, not here)
// ---------------------------------------------------------------------------
package add_seq_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_SLICE = 4;

  // Sequencer state encoding, kept as plain constants so older tools and
  // scripts that probe the raw state register keep working.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // A counter needs at least one bit even when there is only one slice.
  function automatic int idx_width(input int n);
    if (n <= 1) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/rca_add_sequencer_if.sv
// ---------------------------------------------------------------------------
// rca_add_sequencer_if
//
// Purpose : request/result bundle between a requester and the add sequencer.
// Signals : start      request, honoured only while busy=0
//           a, b, cin  operands, captured on the accepting edge
//           sub        (ADD_SEQ_SUBTRACT_EN only) select a-b instead of a+b+cin
//           busy       slices are being processed
//           done       one-cycle pulse, sum/cout valid
//           sum, cout  registered result
// Modports: master = requester, slave = sequencer.
// Optional: ADD_SEQ_SUBTRACT_EN adds the sub signal.
// ---------------------------------------------------------------------------
interface rca_add_sequencer_if
  import add_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef ADD_SEQ_SUBTRACT_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

`ifdef ADD_SEQ_SUBTRACT_EN
  modport master (output start, a, b, cin, sub, input  busy, done, sum, cout);
  modport slave  (input  start, a, b, cin, sub, output busy, done, sum, cout);
`else
  modport master (output start, a, b, cin, input  busy, done, sum, cout);
  modport slave  (input  start, a, b, cin, output busy, done, sum, cout);
`endif

endinterface

// File: rtl/rca_add_sequencer_slice.sv
// ---------------------------------------------------------------------------
// rca_slice
//
// Purpose : SLICE-bit combinational ripple-carry adder; the one shared
//           arithmetic element the sequencer steps across the operands.
// Ports   : a, b  [SLICE-1:0]  slice operands
//           cin                carry into bit 0
//           sum   [SLICE-1:0]  slice sum
//           cout               carry out of the top bit
// ---------------------------------------------------------------------------
module rca_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout
);

  logic [SLICE:0] carry;

  // Explicit full-adder chain so the ripple structure is preserved.
  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = cin;
    for (int i = 0; i < SLICE; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
    cout = carry[SLICE];
  end

endmodule

// File: rtl/rca_add_sequencer.sv
// ---------------------------------------------------------------------------
// rca_add_sequencer
//
// Purpose : adds WIDTH-bit operands one SLICE-bit slice per clock, LSB first,
//           reusing a single rca_slice with the carry registered between
//           slices. Returns a registered sum/cout with a one-cycle done pulse.
// Ports   : clk   rising-edge clock
//           rst   synchronous active-high reset
//           bus   rca_add_sequencer_if.slave (start/a/b/cin[/sub] in,
//                 busy/done/sum/cout out)
// Params  : WIDTH (multiple of SLICE), SLICE
// Optional: ADD_SEQ_SUBTRACT_EN - when defined, bus.sub=1 latches ~b and a
//           forced carry-in of 1, producing a-b; cout=1 then means no borrow.
// ---------------------------------------------------------------------------
module rca_add_sequencer
  import add_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int SLICE = DEFAULT_SLICE
) (
  input logic                clk,
  input logic                rst,
  rca_add_sequencer_if.slave bus
);

  localparam int NUM_SLICES = WIDTH / SLICE;
  localparam int IW         = idx_width(NUM_SLICES);
  localparam int BW         = idx_width(WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_SLICES - 1);

  if ((WIDTH % SLICE) != 0) begin : g_width_check
    $error("rca_add_sequencer: WIDTH (%0d) must be a multiple of SLICE (%0d)", WIDTH, SLICE);
  end

  logic [1:0]       state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [BW-1:0]    base;
  logic [SLICE-1:0] slice_a;
  logic [SLICE-1:0] slice_b;
  logic [SLICE-1:0] slice_sum;
  logic             slice_cout;

  // Bit offset of the slice currently being processed.
  always_comb begin
    base    = BW'(idx_q) * BW'(SLICE);
    slice_a = a_q[base +: SLICE];
    slice_b = b_q[base +: SLICE];
  end

  rca_slice #(
    .SLICE (SLICE)
  ) u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // Next-state logic. DONE accepts a new start exactly like IDLE so that a
  // requester can issue back-to-back operations without a bubble. sum is
  // left untouched on acceptance; it is overwritten slice by slice in RUN.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    busy_d  = busy_q;
    done_d  = done_q;

    case (state_q)
      ST_RUN: begin
        sum_d[base +: SLICE] = slice_sum;
        carry_d              = slice_cout;
        if (idx_q == LAST_IDX) begin
          cout_d  = slice_cout;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end

      default: begin
        done_d  = 1'b0;
        state_d = ST_IDLE;
        if (bus.start) begin
          a_d     = bus.a;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_RUN;
`ifdef ADD_SEQ_SUBTRACT_EN
          // Two's-complement subtract: a + ~b + 1.
          if (bus.sub) begin
            b_d     = ~bus.b;
            carry_d = 1'b1;
          end else begin
            b_d     = bus.b;
            carry_d = bus.cin;
          end
`else
          b_d     = bus.b;
          carry_d = bus.cin;
`endif
        end
      end
    endcase
  end

  // Control and result registers; reset wins over everything, so an
  // in-flight operation is dropped without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Operand holding registers only matter after an accepted start.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_rca_add_sequencer.sv
// ---------------------------------------------------------------------------
// tb_rca_add_sequencer
//
// Self-checking bench for rca_add_sequencer: a 16-bit/4-bit instance driven
// from a vector table, hand-written multi-cycle sequences and random
// operations, plus an 8-bit/4-bit instance driven with random operands.
// Optional: ADD_SEQ_SUBTRACT_EN enables the subtract vectors and random sub.
// ---------------------------------------------------------------------------
module tb_rca_add_sequencer;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  int check_count = 0;
  int pass_count  = 0;

  rca_add_sequencer_if #(.WIDTH(16)) bus16 ();
  rca_add_sequencer_if #(.WIDTH(8))  bus8  ();

  rca_add_sequencer #(.WIDTH(16), .SLICE(4)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (bus16)
  );

  rca_add_sequencer #(.WIDTH(8), .SLICE(4)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  typedef struct {
    string       name;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] exp_sum;
    logic        exp_cout;
  } vec_t;

  vec_t vecs[$];

  // Reference: plain arithmetic on the whole operands.
  function automatic logic [16:0] model16(input logic [15:0] a, input logic [15:0] b,
                                          input logic cin, input logic sub);
    logic [15:0] diff;
    if (sub) begin
      diff = a - b;
      return {(a >= b), diff};
    end
    return 17'(a) + 17'(b) + 17'(cin);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_count++;
    if (act === exp) pass_count++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Drives one start pulse; returns at the negedge after the accepting edge.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                               input logic cin, input logic sub);
    @(negedge clk);
    bus16.start = 1'b1;
    bus16.a     = a;
    bus16.b     = b;
    bus16.cin   = cin;
`ifdef ADD_SEQ_SUBTRACT_EN
    bus16.sub   = sub;
`else
    if (sub) $display("[TB] subtract requested without ADD_SEQ_SUBTRACT_EN");
`endif
    @(negedge clk);
    bus16.start = 1'b0;
    bus16.a     = 16'($urandom);
    bus16.b     = 16'($urandom);
    bus16.cin   = 1'($urandom);
  endtask

  // Waits (bounded) for done; cyc0 = cycles already elapsed since accept.
  task automatic waitDone(input int cyc0, output int lat, output int busy_cnt,
                          output logic [15:0] s, output logic c);
    int cyc;
    cyc      = cyc0;
    busy_cnt = 0;
    while (bus16.done !== 1'b1 && cyc < 20) begin
      if (bus16.busy === 1'b1) busy_cnt++;
      @(negedge clk);
      cyc++;
    end
    lat = cyc - 1;
    s   = bus16.sum;
    c   = bus16.cout;
  endtask

  initial begin
    int          lat;
    int          busy_cnt;
    int          dones;
    logic [15:0] s;
    logic        c;
    logic [16:0] exp17;
    logic [15:0] ra, rb;
    logic        rc, rs;
    logic [7:0]  a8, b8;
    logic        c8;
    int          cyc;

    rst         = 1'b1;
    bus16.start = 1'b0; bus16.a = '0; bus16.b = '0; bus16.cin = 1'b0;
    bus8.start  = 1'b0; bus8.a  = '0; bus8.b  = '0; bus8.cin  = 1'b0;
`ifdef ADD_SEQ_SUBTRACT_EN
    bus16.sub = 1'b0;
    bus8.sub  = 1'b0;
`endif
    repeat (3) @(negedge clk);
    checkOutput("reset busy", bus16.busy, 0);
    checkOutput("reset done", bus16.done, 0);
    checkOutput("reset sum",  bus16.sum,  0);
    checkOutput("reset cout", bus16.cout, 0);
    checkOutput("reset sum8", {bus8.cout, bus8.sum}, 0);
    rst = 1'b0;

    vecs.push_back('{"basic",      16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0});
    vecs.push_back('{"ripple_all", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1});
    vecs.push_back('{"ripple_mid", 16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0});
    vecs.push_back('{"max",        16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1});
    vecs.push_back('{"zero",       16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0});
    vecs.push_back('{"msb_carry",  16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1});
    vecs.push_back('{"nib_carry",  16'h00F0, 16'h0010, 1'b0, 1'b0, 16'h0100, 1'b0});
`ifdef ADD_SEQ_SUBTRACT_EN
    vecs.push_back('{"sub_borrow", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0});
    vecs.push_back('{"sub_ok",     16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1});
`endif

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
      waitDone(1, lat, busy_cnt, s, c);
      checkOutput({vecs[i].name, " sum"},     s, vecs[i].exp_sum);
      checkOutput({vecs[i].name, " cout"},    c, vecs[i].exp_cout);
      checkOutput({vecs[i].name, " latency"}, lat, 4);
      checkOutput({vecs[i].name, " busy"},    busy_cnt, 4);
      checkOutput({vecs[i].name, " busy@done"}, bus16.busy, 0);
      @(negedge clk);
      checkOutput({vecs[i].name, " done pulse"}, bus16.done, 0);
      checkOutput({vecs[i].name, " sum hold"},   bus16.sum, vecs[i].exp_sum);
    end

    // Back-to-back: new start held during the DONE cycle.
    applyStimulus(16'h1234, 16'h1111, 1'b0, 1'b0);
    waitDone(1, lat, busy_cnt, s, c);
    checkOutput("b2b first sum", s, 16'h2345);
    bus16.start = 1'b1;
    bus16.a     = 16'h0001;
    bus16.b     = 16'h0002;
    bus16.cin   = 1'b0;
    @(negedge clk);
    bus16.start = 1'b0;
    checkOutput("b2b busy again", bus16.busy, 1);
    waitDone(1, lat, busy_cnt, s, c);
    checkOutput("b2b second sum",     s, 16'h0003);
    checkOutput("b2b second cout",    c, 0);
    checkOutput("b2b second latency", lat, 4);

    // Start pulsed mid-RUN must be ignored.
    applyStimulus(16'h1234, 16'h1111, 1'b0, 1'b0);
    bus16.start = 1'b1;
    bus16.a     = 16'hFFFF;
    bus16.b     = 16'hFFFF;
    bus16.cin   = 1'b1;
    @(negedge clk);
    bus16.start = 1'b0;
    waitDone(2, lat, busy_cnt, s, c);
    checkOutput("midrun sum",     s, 16'h2345);
    checkOutput("midrun cout",    c, 0);
    checkOutput("midrun latency", lat, 4);
    @(negedge clk);
    checkOutput("midrun no restart", bus16.busy, 0);

    // Reset during the second RUN cycle.
    applyStimulus(16'h1234, 16'h1111, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst busy", bus16.busy, 0);
    checkOutput("rst done", bus16.done, 0);
    checkOutput("rst sum",  bus16.sum,  0);
    checkOutput("rst cout", bus16.cout, 0);
    dones = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus16.done === 1'b1) dones++;
    end
    checkOutput("rst no done", dones, 0);
    applyStimulus(16'h0FFF, 16'h0001, 1'b0, 1'b0);
    waitDone(1, lat, busy_cnt, s, c);
    checkOutput("post-rst sum",     s, 16'h1000);
    checkOutput("post-rst latency", lat, 4);

    // Random 16-bit operations.
    for (int n = 0; n < 150; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
`ifdef ADD_SEQ_SUBTRACT_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      exp17 = model16(ra, rb, rc, rs);
      applyStimulus(ra, rb, rc, rs);
      waitDone(1, lat, busy_cnt, s, c);
      checkOutput($sformatf("rand16 %0h %0h %0b %0b", ra, rb, rc, rs), {c, s}, exp17);
    end

    // Random 8-bit operations with corner operands first.
    for (int n = 0; n < 300; n++) begin
      a8 = (n < 4) ? ((n[0]) ? 8'hFF : 8'h00) : 8'($urandom);
      b8 = (n < 4) ? ((n[1]) ? 8'hFF : 8'h00) : 8'($urandom);
      c8 = (n < 4) ? n[0] : 1'($urandom);
      @(negedge clk);
      bus8.start = 1'b1;
      bus8.a     = a8;
      bus8.b     = b8;
      bus8.cin   = c8;
      @(negedge clk);
      bus8.start = 1'b0;
      bus8.a     = 8'($urandom);
      bus8.b     = 8'($urandom);
      cyc = 1;
      while (bus8.done !== 1'b1 && cyc < 12) begin
        @(negedge clk);
        cyc++;
      end
      checkOutput($sformatf("rand8 latency %0d", n), cyc - 1, 2);
      checkOutput($sformatf("rand8 %0h %0h %0b", a8, b8, c8), {bus8.cout, bus8.sum},
                  9'(a8) + 9'(b8) + 9'(c8));
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
